// File: rtl/instr_decode_pipe_if.sv
// instr_decode_pipe_if
//   Bundles the two valid/ready channels of the decode stage.
//   fetched_* : raw instruction word and its pc, flowing into the pipe.
//   decoded_* : decoded fields, resolved operand values and illegal flag,
//               flowing out of the pipe.
//   Modports:
//     master : the surrounding pipeline (drives fetched_*, consumes decoded_*)
//     slave  : the decode pipe itself
//   op encoding : 0 LOAD, 1 MISC_MEM, 2 OP_IMM, 3 AUIPC, 4 STORE, 5 OP,
//                 6 LUI, 7 BRANCH, 8 JALR, 9 JAL, 10 SYSTEM, 15 INSTR_INVAL
//   fmt encoding: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J
interface instr_decode_pipe_if;
   logic        fetched_valid;
   logic        fetched_ready;
   logic [31:0] fetched_raw;
   logic [31:0] fetched_pc;

   logic        decoded_valid;
   logic        decoded_ready;
   logic [3:0]  decoded_op;
   logic [2:0]  decoded_fmt;
   logic [4:0]  decoded_rd;
   logic [4:0]  decoded_rs1;
   logic [4:0]  decoded_rs2;
   logic [2:0]  decoded_funct3;
   logic [31:0] decoded_imm;
   logic [31:0] decoded_rs1_val;
   logic [31:0] decoded_rs2_val;
   logic [31:0] decoded_pc;
   logic        decoded_illegal;

   modport master (
      output fetched_valid, fetched_raw, fetched_pc, decoded_ready,
      input  fetched_ready,
      input  decoded_valid, decoded_op, decoded_fmt, decoded_rd, decoded_rs1,
             decoded_rs2, decoded_funct3, decoded_imm, decoded_rs1_val,
             decoded_rs2_val, decoded_pc, decoded_illegal
   );

   modport slave (
      input  fetched_valid, fetched_raw, fetched_pc, decoded_ready,
      output fetched_ready,
      output decoded_valid, decoded_op, decoded_fmt, decoded_rd, decoded_rs1,
             decoded_rs2, decoded_funct3, decoded_imm, decoded_rs1_val,
             decoded_rs2_val, decoded_pc, decoded_illegal
   );
endinterface

// File: rtl/instr_decode_pipe.sv
// instr_decode_pipe
//   RV32 instruction decode stage with operand read/forwarding and a small
//   in-order output buffer.
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous active-high reset
//     bus          instr_decode_pipe_if.slave (fetched in, decoded out)
//     o_rs_idx     regfile read indices {rs2, rs1}, combinational from fetched raw
//     i_rs_val     regfile read data, same cycle
//     i_bp_valid   per-port writeback forwarding strobe
//     i_bp_idx     per-port forwarded destination register
//     i_bp_val     per-port forwarded value
//     i_flush      drop buffered and incoming instructions
//     o_count      number of occupied buffer entries
module instr_decode_pipe #(
   parameter int DEPTH   = 2,
   parameter int NBYPASS = 2,
   localparam int NBP    = (NBYPASS > 0) ? NBYPASS : 1,
   localparam int CW     = $clog2(DEPTH + 1),
   localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   instr_decode_pipe_if.slave    bus,
   output logic [1:0][4:0]       o_rs_idx,
   input  logic [1:0][31:0]      i_rs_val,
   input  logic [NBP-1:0]        i_bp_valid,
   input  logic [NBP-1:0][4:0]   i_bp_idx,
   input  logic [NBP-1:0][31:0]  i_bp_val,
   input  logic                  i_flush,
   output logic [CW-1:0]         o_count
);

   localparam logic [3:0] OP_LOAD   = 4'd0;
   localparam logic [3:0] OP_MISC   = 4'd1;
   localparam logic [3:0] OP_OPIMM  = 4'd2;
   localparam logic [3:0] OP_AUIPC  = 4'd3;
   localparam logic [3:0] OP_STORE  = 4'd4;
   localparam logic [3:0] OP_OP     = 4'd5;
   localparam logic [3:0] OP_LUI    = 4'd6;
   localparam logic [3:0] OP_BRANCH = 4'd7;
   localparam logic [3:0] OP_JALR   = 4'd8;
   localparam logic [3:0] OP_JAL    = 4'd9;
   localparam logic [3:0] OP_SYSTEM = 4'd10;
   localparam logic [3:0] OP_INVAL  = 4'd15;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   typedef struct packed {
      logic [3:0]  op;
      logic [2:0]  fmt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [31:0] imm;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] pc;
      logic        illegal;
   } entry_t;

   entry_t          r_mem [DEPTH];
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [CW-1:0]   r_count;

   logic [31:0]     w_raw;
   logic [3:0]      w_op;
   logic [2:0]      w_fmt;
   logic            w_ill;
   entry_t          w_dec;
   entry_t          w_new;
   logic [32:0]     w_acc1;
   logic [32:0]     w_acc2;
   logic [32:0]     w_fwd1 [DEPTH];
   logic [32:0]     w_fwd2 [DEPTH];
   logic            w_ready;
   logic            w_push;
   logic            w_pop;

   // {hit, value}; later ports override earlier ones, x0 never matches.
   function automatic logic [32:0] fwd_lookup(
      input logic [4:0]            idx,
      input logic [NBP-1:0]        bv,
      input logic [NBP-1:0][4:0]   bi,
      input logic [NBP-1:0][31:0]  bd
   );
      logic [32:0] res;
      res = '0;
      for (int p = 0; p < NBYPASS; p++) begin
         if (bv[p] && (bi[p] == idx) && (idx != 5'd0)) res = {1'b1, bd[p]};
      end
      return res;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   assign w_raw = bus.fetched_raw;

   always_comb begin
      w_op  = OP_INVAL;
      w_fmt = FMT_I;
      w_ill = 1'b1;
      if (w_raw[1:0] == 2'b11) begin
         w_ill = 1'b0;
         case (w_raw[6:2])
            5'b00000: begin w_op = OP_LOAD;   w_fmt = FMT_I; end
            5'b00011: begin w_op = OP_MISC;   w_fmt = FMT_I; end
            5'b00100: begin w_op = OP_OPIMM;  w_fmt = FMT_I; end
            5'b00101: begin w_op = OP_AUIPC;  w_fmt = FMT_U; end
            5'b01000: begin w_op = OP_STORE;  w_fmt = FMT_S; end
            5'b01100: begin w_op = OP_OP;     w_fmt = FMT_R; end
            5'b01101: begin w_op = OP_LUI;    w_fmt = FMT_U; end
            5'b11000: begin w_op = OP_BRANCH; w_fmt = FMT_B; end
            5'b11001: begin w_op = OP_JALR;   w_fmt = FMT_I; end
            5'b11011: begin w_op = OP_JAL;    w_fmt = FMT_J; end
            5'b11100: begin w_op = OP_SYSTEM; w_fmt = FMT_I; end
            default:  begin w_op = OP_INVAL;  w_fmt = FMT_I; w_ill = 1'b1; end
         endcase
      end
   end

   always_comb begin
      w_dec         = '0;
      w_dec.op      = w_op;
      w_dec.fmt     = w_fmt;
      w_dec.illegal = w_ill;
      w_dec.pc      = bus.fetched_pc;
      w_dec.funct3  = w_raw[14:12];
      w_dec.rd      = w_raw[11:7];
      w_dec.rs1     = w_raw[19:15];
      w_dec.rs2     = w_raw[24:20];
      case (w_fmt)
         FMT_U, FMT_J: begin w_dec.rs1 = 5'd0; w_dec.rs2 = 5'd0; end
         FMT_I:        w_dec.rs2 = 5'd0;
         FMT_S, FMT_B: w_dec.rd  = 5'd0;
         default:      ;
      endcase
      case (w_fmt)
         FMT_S:   w_dec.imm = {{20{w_raw[31]}}, w_raw[31:25], w_raw[11:7]};
         FMT_B:   w_dec.imm = {{19{w_raw[31]}}, w_raw[31], w_raw[7], w_raw[30:25],
                               w_raw[11:8], 1'b0};
         FMT_U:   w_dec.imm = {w_raw[31:12], 12'b0};
         FMT_J:   w_dec.imm = {{11{w_raw[31]}}, w_raw[31], w_raw[19:12], w_raw[20],
                               w_raw[30:21], 1'b0};
         default: w_dec.imm = {{20{w_raw[31]}}, w_raw[31:20]};
      endcase
   end

   assign o_rs_idx[0] = w_dec.rs1;
   assign o_rs_idx[1] = w_dec.rs2;

   always_comb begin
      w_acc1 = fwd_lookup(w_dec.rs1, i_bp_valid, i_bp_idx, i_bp_val);
      w_acc2 = fwd_lookup(w_dec.rs2, i_bp_valid, i_bp_idx, i_bp_val);
      w_new  = w_dec;
      if (w_dec.rs1 == 5'd0)  w_new.rs1_val = '0;
      else if (w_acc1[32])    w_new.rs1_val = w_acc1[31:0];
      else                    w_new.rs1_val = i_rs_val[0];
      if (w_dec.rs2 == 5'd0)  w_new.rs2_val = '0;
      else if (w_acc2[32])    w_new.rs2_val = w_acc2[31:0];
      else                    w_new.rs2_val = i_rs_val[1];
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_fwd1[i] = fwd_lookup(r_mem[i].rs1, i_bp_valid, i_bp_idx, i_bp_val);
         w_fwd2[i] = fwd_lookup(r_mem[i].rs2, i_bp_valid, i_bp_idx, i_bp_val);
      end
   end

   // A full buffer can still accept when the head leaves in the same cycle.
   assign w_ready = !i_flush && ((r_count < DEPTH_C) || bus.decoded_ready);
   assign w_push  = bus.fetched_valid && w_ready;
   assign w_pop   = (r_count != '0) && bus.decoded_ready && !i_flush;

   // Stale entries (including free slots) may be refreshed harmlessly; the
   // push write comes last so it wins over any refresh of the tail slot.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_fwd1[i][32]) r_mem[i].rs1_val <= w_fwd1[i][31:0];
         if (w_fwd2[i][32]) r_mem[i].rs2_val <= w_fwd2[i][31:0];
      end
      if (w_push) r_mem[r_tail] <= w_new;
   end

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= ptr_inc(r_tail);
         if (w_pop)  r_head <= ptr_inc(r_head);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count              = r_count;
   assign bus.fetched_ready    = w_ready;
   assign bus.decoded_valid    = (r_count != '0);
   assign bus.decoded_op       = r_mem[r_head].op;
   assign bus.decoded_fmt      = r_mem[r_head].fmt;
   assign bus.decoded_rd       = r_mem[r_head].rd;
   assign bus.decoded_rs1      = r_mem[r_head].rs1;
   assign bus.decoded_rs2      = r_mem[r_head].rs2;
   assign bus.decoded_funct3   = r_mem[r_head].funct3;
   assign bus.decoded_imm      = r_mem[r_head].imm;
   assign bus.decoded_rs1_val  = r_mem[r_head].rs1_val;
   assign bus.decoded_rs2_val  = r_mem[r_head].rs2_val;
   assign bus.decoded_pc       = r_mem[r_head].pc;
   assign bus.decoded_illegal  = r_mem[r_head].illegal;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb_instr_decode_pipe
//   Drives instr_decode_pipe (DEPTH=2, NBYPASS=2) with directed and random
//   traffic. An independent reference decoder and queue predict every output.
module tb_instr_decode_pipe;

   localparam int DEPTH = 2;

   localparam logic [3:0] OP_OPIMM = 4'd2;
   localparam logic [3:0] OP_INVAL = 4'd15;
   localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                          FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5;

   typedef struct packed {
      logic [3:0]  op;
      logic [2:0]  fmt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [31:0] imm;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0][4:0]   rs_idx;
   logic [1:0][31:0]  rs_val;
   logic [1:0]        bp_valid = '0;
   logic [1:0][4:0]   bp_idx   = '0;
   logic [1:0][31:0]  bp_val   = '0;
   logic              flush    = 1'b0;
   logic [1:0]        count;
   logic [31:0]       rf [32];

   int n_checks = 0;
   int n_errors = 0;
   exp_t q[$];

   instr_decode_pipe_if bus ();

   instr_decode_pipe #(.DEPTH(DEPTH), .NBYPASS(2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .o_rs_idx   (rs_idx),
      .i_rs_val   (rs_val),
      .i_bp_valid (bp_valid),
      .i_bp_idx   (bp_idx),
      .i_bp_val   (bp_val),
      .i_flush    (flush),
      .o_count    (count)
   );

   always #5 clk = ~clk;

   assign rs_val[0] = rf[rs_idx[0]];
   assign rs_val[1] = rf[rs_idx[1]];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [32:0] ref_fwd(input logic [4:0] idx);
      logic [32:0] r;
      r = '0;
      if (idx != 5'd0) begin
         if (bp_valid[0] && bp_idx[0] == idx) r = {1'b1, bp_val[0]};
         if (bp_valid[1] && bp_idx[1] == idx) r = {1'b1, bp_val[1]};
      end
      return r;
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] raw, input logic [31:0] pc);
      exp_t e;
      logic [32:0] f;
      e     = '0;
      e.pc  = pc;
      e.f3  = raw[14:12];
      e.rd  = raw[11:7];
      e.rs1 = raw[19:15];
      e.rs2 = raw[24:20];
      e.op  = OP_INVAL;
      e.fmt = FMT_I;
      e.ill = 1'b1;
      if (raw[1:0] == 2'b11) begin
         e.ill = 1'b0;
         case (raw[6:2])
            5'b00000: begin e.op = 4'd0;  e.fmt = FMT_I; end
            5'b00011: begin e.op = 4'd1;  e.fmt = FMT_I; end
            5'b00100: begin e.op = 4'd2;  e.fmt = FMT_I; end
            5'b00101: begin e.op = 4'd3;  e.fmt = FMT_U; end
            5'b01000: begin e.op = 4'd4;  e.fmt = FMT_S; end
            5'b01100: begin e.op = 4'd5;  e.fmt = FMT_R; end
            5'b01101: begin e.op = 4'd6;  e.fmt = FMT_U; end
            5'b11000: begin e.op = 4'd7;  e.fmt = FMT_B; end
            5'b11001: begin e.op = 4'd8;  e.fmt = FMT_I; end
            5'b11011: begin e.op = 4'd9;  e.fmt = FMT_J; end
            5'b11100: begin e.op = 4'd10; e.fmt = FMT_I; end
            default:  e.ill = 1'b1;
         endcase
      end
      if (e.fmt == FMT_U || e.fmt == FMT_J) begin e.rs1 = 0; e.rs2 = 0; end
      if (e.fmt == FMT_I) e.rs2 = 0;
      if (e.fmt == FMT_S || e.fmt == FMT_B) e.rd = 0;
      if (e.fmt == FMT_S)      e.imm = {{20{raw[31]}}, raw[31:25], raw[11:7]};
      else if (e.fmt == FMT_B) e.imm = {{20{raw[31]}}, raw[7], raw[30:25], raw[11:8], 1'b0};
      else if (e.fmt == FMT_U) e.imm = {raw[31:12], 12'h000};
      else if (e.fmt == FMT_J) e.imm = {{12{raw[31]}}, raw[19:12], raw[20], raw[30:21], 1'b0};
      else                     e.imm = {{20{raw[31]}}, raw[31:20]};
      f = ref_fwd(e.rs1);
      e.v1 = (e.rs1 == 0) ? 32'h0 : (f[32] ? f[31:0] : rf[e.rs1]);
      f = ref_fwd(e.rs2);
      e.v2 = (e.rs2 == 0) ? 32'h0 : (f[32] ? f[31:0] : rf[e.rs2]);
      return e;
   endfunction

   // Scoreboard: predicts the upcoming rising edge from inputs settled at negedge.
   always @(negedge clk) begin
      exp_t d, h;
      logic exp_ready, push, pop;
      logic [32:0] f;
      if (rst) begin
         q.delete();
      end else begin
         exp_ready = !flush && (q.size() < DEPTH || bus.decoded_ready);
         chk("fetched_ready", bus.fetched_ready, exp_ready);
         chk("count", count, q.size());
         chk("decoded_valid", bus.decoded_valid, q.size() != 0);
         d = ref_decode(bus.fetched_raw, bus.fetched_pc);
         chk("rs_idx0", rs_idx[0], d.rs1);
         chk("rs_idx1", rs_idx[1], d.rs2);
         push = bus.fetched_valid && exp_ready;
         pop  = (q.size() != 0) && bus.decoded_ready && !flush;
         if (pop) begin
            h = q[0];
            chk("op",      bus.decoded_op,      h.op);
            chk("fmt",     bus.decoded_fmt,     h.fmt);
            chk("rd",      bus.decoded_rd,      h.rd);
            chk("rs1",     bus.decoded_rs1,     h.rs1);
            chk("rs2",     bus.decoded_rs2,     h.rs2);
            chk("funct3",  bus.decoded_funct3,  h.f3);
            chk("imm",     bus.decoded_imm,     h.imm);
            chk("rs1_val", bus.decoded_rs1_val, h.v1);
            chk("rs2_val", bus.decoded_rs2_val, h.v2);
            chk("pc",      bus.decoded_pc,      h.pc);
            chk("illegal", bus.decoded_illegal, h.ill);
         end
         if (flush) begin
            q.delete();
         end else begin
            if (pop) void'(q.pop_front());
            foreach (q[i]) begin
               f = ref_fwd(q[i].rs1);
               if (f[32]) q[i].v1 = f[31:0];
               f = ref_fwd(q[i].rs2);
               if (f[32]) q[i].v2 = f[31:0];
            end
            if (push) q.push_back(d);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] raw, input logic [31:0] pc);
      bus.fetched_valid = 1'b1;
      bus.fetched_raw   = raw;
      bus.fetched_pc    = pc;
   endtask

   function automatic logic [31:0] rand_raw();
      logic [31:0] r;
      logic [4:0]  ops [12];
      ops = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
              5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100, 5'b11111};
      r = $urandom;
      if ($urandom_range(0, 9) != 0) begin
         r[19:15] = 5'($urandom_range(0, 7));
         r[24:20] = 5'($urandom_range(0, 7));
         r[6:2]   = ops[$urandom_range(0, 11)];
         r[1:0]   = 2'b11;
      end
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h100 * i + 32'h7;
      rf[1] = 32'h0;
      bus.fetched_valid = 1'b0;
      bus.fetched_raw   = '0;
      bus.fetched_pc    = '0;
      bus.decoded_ready = 1'b1;

      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_count", count, 0);
      chk("rst_valid", bus.decoded_valid, 0);
      chk("rst_ready", bus.fetched_ready, 1);

      // addi x1,x0,10
      send(32'h00A00093, 32'h100);
      step();
      bus.fetched_valid = 1'b0;
      chk("addi_valid", bus.decoded_valid, 1);
      chk("addi_op",    bus.decoded_op, OP_OPIMM);
      chk("addi_rd",    bus.decoded_rd, 1);
      chk("addi_rs1",   bus.decoded_rs1, 0);
      chk("addi_imm",   bus.decoded_imm, 10);
      chk("addi_ill",   bus.decoded_illegal, 0);
      step();

      // fill, then push and pop in the same cycle while full
      bus.decoded_ready = 1'b0;
      send(32'h002081B3, 32'h200); step();
      send(32'h0062C233, 32'h204); step();
      send(32'h123453B7, 32'h208);
      #1;
      chk("full_count", count, 2);
      chk("full_ready", bus.fetched_ready, 0);
      step();
      bus.decoded_ready = 1'b1;
      #1;
      chk("full_pp_ready", bus.fetched_ready, 1);
      step();
      bus.fetched_valid = 1'b0;
      chk("full_pp_count", count, 2);
      chk("full_pp_head", bus.decoded_pc, 32'h204);
      step(); step(); step();
      chk("drain_count", count, 0);

      // forwarding at accept
      send(32'h002081B3, 32'h300);
      bp_valid = 2'b01; bp_idx[0] = 5'd1; bp_val[0] = 32'hDEAD;
      step();
      chk("bp0_rs1_val", bus.decoded_rs1_val, 32'hDEAD);
      bp_valid = 2'b11; bp_idx[1] = 5'd1; bp_val[1] = 32'hBEEF;
      send(32'h002081B3, 32'h304);
      step();
      chk("bp1_rs1_val", bus.decoded_rs1_val, 32'hBEEF);
      bp_valid = 2'b00;
      bus.fetched_valid = 1'b0;
      step();

      // forwarding into a stalled entry: add x8,x1,x5
      bus.decoded_ready = 1'b0;
      send(32'h00508433, 32'h400);
      step();
      bus.fetched_valid = 1'b0;
      chk("stall_rs2_val", bus.decoded_rs2_val, rf[5]);
      bp_valid = 2'b01; bp_idx[0] = 5'd5; bp_val[0] = 32'h1234;
      step();
      chk("upd_rs2_val", bus.decoded_rs2_val, 32'h1234);
      bp_idx[0] = 5'd0; bp_val[0] = 32'hFFFF;
      step();
      chk("x0_rs2_val", bus.decoded_rs2_val, 32'h1234);
      chk("x0_rs1_val", bus.decoded_rs1_val, rf[1]);
      bp_valid = 2'b00;
      bus.decoded_ready = 1'b1;
      step();

      // flush with two buffered and one incoming
      bus.decoded_ready = 1'b0;
      send(32'h002081B3, 32'h500); step();
      send(32'h0062C233, 32'h504); step();
      send(32'h123453B7, 32'h508);
      flush = 1'b1;
      #1;
      chk("flush_ready", bus.fetched_ready, 0);
      step();
      flush = 1'b0;
      bus.fetched_valid = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_valid", bus.decoded_valid, 0);
      step();
      chk("flush_drop", bus.decoded_valid, 0);
      bus.decoded_ready = 1'b1;

      // illegal encodings, then a legal one
      send(32'h00000000, 32'h600); step();
      chk("ill0_ill", bus.decoded_illegal, 1);
      chk("ill0_op",  bus.decoded_op, OP_INVAL);
      send(32'hFFFFFFFF, 32'h604); step();
      chk("ill1_ill", bus.decoded_illegal, 1);
      chk("ill1_op",  bus.decoded_op, OP_INVAL);
      chk("ill1_fmt", bus.decoded_fmt, FMT_I);
      send(32'h00A00093, 32'h608); step();
      chk("post_ill_op",  bus.decoded_op, OP_OPIMM);
      chk("post_ill_ill", bus.decoded_illegal, 0);
      bus.fetched_valid = 1'b0;
      step();

      // reset mid-stream
      bus.decoded_ready = 1'b0;
      send(32'h002081B3, 32'h700); step();
      send(32'h0062C233, 32'h704); step();
      bus.fetched_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_valid", bus.decoded_valid, 0);
      chk("mid_rst_ready", bus.fetched_ready, 1);

      // random traffic
      for (int c = 0; c < 400; c++) begin
         bus.fetched_valid = ($urandom_range(0, 3) != 0);
         bus.fetched_raw   = rand_raw();
         bus.fetched_pc    = $urandom;
         bus.decoded_ready = ($urandom_range(0, 2) != 0);
         flush             = ($urandom_range(0, 19) == 0);
         for (int p = 0; p < 2; p++) begin
            bp_valid[p] = ($urandom_range(0, 1) == 1);
            bp_idx[p]   = 5'($urandom_range(0, 7));
            bp_val[p]   = $urandom;
         end
         step();
      end

      bus.fetched_valid = 1'b0;
      bus.decoded_ready = 1'b1;
      flush    = 1'b0;
      bp_valid = '0;
      repeat (4) step();
      chk("end_count", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
